// File: rtl/vga_sync_generator_if.sv
// rtl/vga_sync_generator_if.sv - pixel tick / colour request in, VGA timing and gated colour out
interface vga_sync_generator_if #(
  parameter int COUNT_WIDTH  = 10,
  parameter int COLOUR_WIDTH = 12
);
  logic                    pixel_trig;
  logic [COLOUR_WIDTH-1:0] colour_in;
  logic                    hs;
  logic                    vs;
  logic [COUNT_WIDTH-1:0]  x;
  logic [COUNT_WIDTH-1:0]  y;
  logic                    display_on;
  logic                    frame_trig;
  logic [COLOUR_WIDTH-1:0] colour_out;

  modport master (
    output pixel_trig, colour_in,
    input  hs, vs, x, y, display_on, frame_trig, colour_out
  );

  modport slave (
    input  pixel_trig, colour_in,
    output hs, vs, x, y, display_on, frame_trig, colour_out
  );
endinterface

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA H/V timing generator with per-frame double-buffered colour
module vga_sync_generator #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int SYNC_POL     = 0,
  parameter int COUNT_WIDTH  = 10,
  parameter int COLOUR_WIDTH = 12
) (
  input logic                 clk,
  input logic                 reset,
  vga_sync_generator_if.slave bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_WIDTH-1:0] H_LAST   = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST   = COUNT_WIDTH'(V_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] H_VIS    = COUNT_WIDTH'(H_VISIBLE);
  localparam logic [COUNT_WIDTH-1:0] V_VIS    = COUNT_WIDTH'(V_VISIBLE);
  localparam logic [COUNT_WIDTH-1:0] HS_START = COUNT_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_WIDTH-1:0] HS_END   = COUNT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COUNT_WIDTH-1:0] VS_START = COUNT_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_WIDTH-1:0] VS_END   = COUNT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic                   ACTIVE   = (SYNC_POL != 0);

  logic [COUNT_WIDTH-1:0]  h_cnt, v_cnt;
  logic [COUNT_WIDTH-1:0]  h_next, v_next;
  logic                    hs_r, vs_r, display_r, frame_r;
  logic [COLOUR_WIDTH-1:0] shadow, colour_r;
  logic                    line_wrap, frame_start, visible_next, hs_next, vs_next;

  always_comb begin
    line_wrap = (h_cnt == H_LAST);
    h_next    = h_cnt + COUNT_WIDTH'(1);
    v_next    = v_cnt;
    if (line_wrap) begin
      h_next = '0;
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + COUNT_WIDTH'(1);
    end
    // (0, V_VISIBLE) is only ever reached through a line wrap
    frame_start  = line_wrap && (v_next == V_VIS);
    visible_next = (h_next < H_VIS) && (v_next < V_VIS);
    hs_next      = ((h_next >= HS_START) && (h_next < HS_END)) ? ACTIVE : ~ACTIVE;
    vs_next      = ((v_next >= VS_START) && (v_next < VS_END)) ? ACTIVE : ~ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      hs_r      <= ~ACTIVE;
      vs_r      <= ~ACTIVE;
      display_r <= 1'b0;
      frame_r   <= 1'b0;
      shadow    <= '0;
      colour_r  <= '0;
    end else if (bus.pixel_trig) begin
      h_cnt     <= h_next;
      v_cnt     <= v_next;
      hs_r      <= hs_next;
      vs_r      <= vs_next;
      display_r <= visible_next;
      frame_r   <= frame_start;
      if (frame_start) shadow <= bus.colour_in;
      // shadow load and visible output never coincide: the frame start line is blanked
      colour_r  <= visible_next ? shadow : '0;
    end else begin
      frame_r <= 1'b0;
    end
  end

  assign bus.x          = h_cnt;
  assign bus.y          = v_cnt;
  assign bus.hs         = hs_r;
  assign bus.vs         = vs_r;
  assign bus.display_on = display_r;
  assign bus.frame_trig = frame_r;
  assign bus.colour_out = colour_r;

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - randomized bench against a frame-position reference model
module tb_vga_sync_generator;

  localparam int HV = 8, HF = 2, HSY = 3, HB = 2;
  localparam int VV = 6, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int CW = 10;
  localparam int KW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_sync_generator_if #(.COUNT_WIDTH(CW), .COLOUR_WIDTH(KW)) bus ();

  vga_sync_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SYNC_POL(0), .COUNT_WIDTH(CW), .COLOUR_WIDTH(KW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // reference state: linear tick position inside the frame
  int          m_pos = 0;
  bit          m_started = 0;
  bit          m_ft = 0;
  logic [KW-1:0] m_shadow = '0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int  h, v;
    bit  vis;
    h   = m_pos % HT;
    v   = m_pos / HT;
    vis = m_started && (h < HV) && (v < VV);
    check("x", 32'(bus.x), 32'(h));
    check("y", 32'(bus.y), 32'(v));
    check("hs", 32'(bus.hs), (h >= HV + HF && h < HV + HF + HSY) ? 32'd0 : 32'd1);
    check("vs", 32'(bus.vs), (v >= VV + VF && v < VV + VF + VSY) ? 32'd0 : 32'd1);
    check("display_on", 32'(bus.display_on), 32'(vis));
    check("frame_trig", 32'(bus.frame_trig), 32'(m_ft));
    check("colour_out", 32'(bus.colour_out), vis ? 32'(m_shadow) : 32'd0);
  endtask

  task automatic cycle(input bit rst, input bit trig);
    reset = rst;
    bus.pixel_trig = trig;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_pos = 0; m_started = 0; m_shadow = '0; m_ft = 0;
    end else if (trig) begin
      m_pos = (m_pos + 1) % FRAME;
      m_started = 1;
      m_ft = (m_pos == VV * HT);
      if (m_ft) m_shadow = bus.colour_in;
    end else begin
      m_ft = 0;
    end
    #1;
    check_all();
  endtask

  initial begin
    int ft_count, vis_count, last_ft, n;
    bit done;
    reset = 1'b1;
    bus.pixel_trig = 1'b0;
    bus.colour_in = 12'hF00;

    // reset state, then one tick every fourth clock for two frames
    cycle(1, 1);
    ft_count = 0; vis_count = 0;
    for (int i = 0; i < 2 * FRAME * 4; i++) begin
      if (m_pos / HT == 2) bus.colour_in = 12'h0F0;
      cycle(0, (i % 4) == 3);
      if (bus.frame_trig) ft_count++;
      if ((i % 4) == 3 && bus.display_on) vis_count++;
    end
    check("frame_pulses_two_frames", 32'(ft_count), 32'd2);
    check("visible_ticks_two_frames", 32'(vis_count), 32'(2 * HV * VV));

    // random tick duty, random colour requests, rare resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) bus.colour_in = KW'($urandom);
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0);
    end

    // freeze mid-line at x=5
    done = 0;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      cycle(0, 1);
      done = (m_pos % HT == 5) && (m_pos / HT < VV);
    end
    check("reach_hold_point", 32'(done), 32'd1);
    for (int i = 0; i < 1000; i++) cycle(0, 0);
    cycle(0, 1);
    check("resume_x", 32'(bus.x), 32'd6);

    // stuck-high ticks: frame period equals FRAME clocks
    cycle(1, 0);
    ft_count = 0; last_ft = -1; n = 0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      cycle(0, 1);
      if (bus.frame_trig) begin
        if (last_ft >= 0) check("frame_period", 32'(i - last_ft), 32'(FRAME));
        last_ft = i;
        ft_count++;
      end
    end
    check("frame_pulses_stuck_high", 32'(ft_count), 32'd2);

    // reset inside both sync pulses with a tick pending
    done = 0;
    for (int i = 0; i < 2 * FRAME && !done; i++) begin
      cycle(0, 1);
      done = (m_pos % HT == HV + HF + 1) && (m_pos / HT == VV + VF);
    end
    check("reach_sync_point", 32'(done), 32'd1);
    check("hs_active_before_reset", 32'(bus.hs), 32'd0);
    check("vs_active_before_reset", 32'(bus.vs), 32'd0);
    cycle(1, 1);
    check("hs_after_reset", 32'(bus.hs), 32'd1);
    check("vs_after_reset", 32'(bus.vs), 32'd1);
    check("x_after_reset", 32'(bus.x), 32'd0);
    for (int i = 0; i < 20; i++) cycle(0, i % 2 == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
